// File: rtl/max_q_select_fp.sv
// max_q_select_fp: streaming fp32 max/argmax over NUM_ACTIONS Q-values per set
module max_q_select_fp #(
  parameter int NUM_ACTIONS = 4,
  parameter int IDX_W       = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             valid_in,
  input  logic [31:0]      q_in,
  output logic [31:0]      max_q,
  output logic [IDX_W-1:0] max_idx,
  output logic             valid_out,
  output logic             busy
);
  typedef enum logic {IDLE, ACCUM} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ACTIONS - 1);
  state_t           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] run_idx_q;
  logic [31:0]      run_max_q;
  logic             take_d;
  // fp32 ordering on raw fields; +0 and -0 are equal so ties keep the older value
  function automatic logic gt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return !a[31] && (a[30:0] != '0 || b[30:0] != '0);
    return a[31] ? (a[30:0] < b[30:0]) : (a[30:0] > b[30:0]);
  endfunction
  // new beat strictly beats the running max
  always_comb take_d = gt(q_in, run_max_q);
  assign busy = (state_q == ACCUM);
  // set accumulation FSM; the last beat writes the result registers directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      run_idx_q <= '0;
      run_max_q <= '0;
      max_q     <= '0;
      max_idx   <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if (valid_in) begin
        if (state_q == IDLE) begin
          run_max_q <= q_in;
          run_idx_q <= '0;
          cnt_q     <= IDX_W'(1);
          state_q   <= ACCUM;
        end else if (cnt_q == LAST) begin
          max_q     <= take_d ? q_in : run_max_q;
          max_idx   <= take_d ? cnt_q : run_idx_q;
          valid_out <= 1'b1;
          cnt_q     <= '0;
          state_q   <= IDLE;
        end else begin
          if (take_d) begin
            run_max_q <= q_in;
            run_idx_q <= cnt_q;
          end
          cnt_q <= cnt_q + IDX_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_max_q_select_fp.sv
// tb_max_q_select_fp: directed table, async reset sequence and randomized model check
module tb_max_q_select_fp;
  localparam int N = 4;
  logic        clk = 1'b0;
  logic        rst_n, clear, valid_in;
  logic [31:0] q_in, max_q;
  logic [1:0]  max_idx;
  logic        valid_out, busy;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic        c, v;
    logic [31:0] q;
    logic        vo;
    logic [31:0] eq;
    logic [1:0]  ei;
    logic        eb;
  } row_t;
  row_t rows[$];
  logic [31:0] beats[$];
  logic [31:0] m_q;
  logic [1:0]  m_i;
  logic [31:0] pool[6] = '{32'h0, 32'h80000000, 32'h3F800000, 32'hBF800000, 32'h40000000, 32'hC0000000};

  max_q_select_fp #(.NUM_ACTIONS(N), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in), .q_in(q_in),
    .max_q(max_q), .max_idx(max_idx), .valid_out(valid_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic longint key(input logic [31:0] x);
    longint k = longint'(x[30:0]);
    return x[31] ? -k : k;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic add(input logic c, v, input logic [31:0] q, input logic vo,
                     input logic [31:0] eq, input logic [1:0] ei, input logic eb);
    rows.push_back('{c, v, q, vo, eq, ei, eb});
  endtask

  task automatic cyc(input logic c, v, input logic [31:0] q, input logic vo,
                     input logic [31:0] eq, input logic [1:0] ei, input logic eb);
    clear = c; valid_in = v; q_in = q;
    @(negedge clk);
    chk("valid_out", 32'(valid_out), 32'(vo));
    chk("max_q", max_q, eq);
    chk("max_idx", 32'(max_idx), 32'(ei));
    chk("busy", 32'(busy), 32'(eb));
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; valid_in = 1'b0; q_in = '0;
    #3;
    chk("rst valid_out", 32'(valid_out), 0);
    chk("rst max_q", max_q, 0);
    chk("rst max_idx", 32'(max_idx), 0);
    chk("rst busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // basic set
    add(0,1,32'h3F800000, 0,32'h0,0,1);
    add(0,1,32'h40000000, 0,32'h0,0,1);
    add(0,1,32'hBF800000, 0,32'h0,0,1);
    add(0,1,32'h3F000000, 1,32'h40000000,1,0);
    add(0,0,32'h0,        0,32'h40000000,1,0);
    // all negative with tie
    add(0,1,32'hBF800000, 0,32'h40000000,1,1);
    add(0,1,32'hC0000000, 0,32'h40000000,1,1);
    add(0,1,32'hBF800000, 0,32'h40000000,1,1);
    add(0,1,32'hC0400000, 1,32'hBF800000,0,0);
    add(0,0,32'h0,        0,32'hBF800000,0,0);
    // signed zeros with gaps
    add(0,1,32'h80000000, 0,32'hBF800000,0,1);
    add(0,0,32'h0,        0,32'hBF800000,0,1);
    add(0,0,32'h0,        0,32'hBF800000,0,1);
    add(0,1,32'h00000000, 0,32'hBF800000,0,1);
    add(0,1,32'hBF000000, 0,32'hBF800000,0,1);
    add(0,0,32'h0,        0,32'hBF800000,0,1);
    add(0,1,32'h80000000, 1,32'h80000000,0,0);
    // back-to-back sets
    add(0,1,32'h3F800000, 0,32'h80000000,0,1);
    add(0,1,32'h40400000, 0,32'h80000000,0,1);
    add(0,1,32'h40000000, 0,32'h80000000,0,1);
    add(0,1,32'h3F800000, 1,32'h40400000,1,0);
    add(0,1,32'hBF800000, 0,32'h40400000,1,1);
    add(0,1,32'hBF800000, 0,32'h40400000,1,1);
    add(0,1,32'hBF800000, 0,32'h40400000,1,1);
    add(0,1,32'h3F000000, 1,32'h3F000000,3,0);
    add(0,0,32'h0,        0,32'h3F000000,3,0);
    // clear mid-set discards the presented beat
    add(0,1,32'h40400000, 0,32'h3F000000,3,1);
    add(0,1,32'h40000000, 0,32'h3F000000,3,1);
    add(1,1,32'h41000000, 0,32'h3F000000,3,0);
    add(0,1,32'h3F800000, 0,32'h3F000000,3,1);
    add(0,1,32'h3F800000, 0,32'h3F000000,3,1);
    add(0,1,32'h3F800000, 0,32'h3F000000,3,1);
    add(0,1,32'h3F800000, 1,32'h3F800000,0,0);
    add(0,0,32'h0,        0,32'h3F800000,0,0);
    foreach (rows[i]) cyc(rows[i].c, rows[i].v, rows[i].q, rows[i].vo, rows[i].eq, rows[i].ei, rows[i].eb);
    // async reset in the middle of a set
    cyc(0,1,32'h40A00000, 0,32'h3F800000,0,1);
    cyc(0,1,32'h40C00000, 0,32'h3F800000,0,1);
    valid_in = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst valid_out", 32'(valid_out), 0);
    chk("arst max_q", max_q, 0);
    chk("arst max_idx", 32'(max_idx), 0);
    chk("arst busy", 32'(busy), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cyc(0,1,32'h40000000, 0,32'h0,0,1);
    cyc(0,1,32'h3F800000, 0,32'h0,0,1);
    cyc(0,1,32'h40800000, 0,32'h0,0,1);
    cyc(0,1,32'hC0000000, 1,32'h40800000,2,0);
    // randomized traffic against a value-ordering reference model
    m_q = 32'h40800000; m_i = 2'd2;
    for (int n = 0; n < 400; n++) begin
      logic c, v, vo;
      logic [31:0] q;
      c = ($urandom_range(0, 15) == 0);
      v = ($urandom_range(0, 2) != 0);
      q = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      vo = 1'b0;
      if (c) beats.delete();
      else if (v) begin
        beats.push_back(q);
        if (beats.size() == N) begin
          m_i = 0;
          for (int k = 1; k < N; k++) if (key(beats[k]) > key(beats[m_i])) m_i = 2'(k);
          m_q = beats[m_i];
          vo = 1'b1;
          beats.delete();
        end
      end
      cyc(c, v, q, vo, m_q, m_i, beats.size() != 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/max_q_select_fp.md
Name: max_q_select_fp

Overview:
- Streaming IEEE-754 single-precision max/argmax selector for the Q-learning datapath.
- Accepts the NUM_ACTIONS Q-values of one state, one per valid beat, in action order.
- Returns the largest value and its action index.
- Output feeds the fp adder/multiplier chain that forms r + gamma*maxQ, so max_q uses the same 32-bit sign/exponent/mantissa layout and a one-cycle valid_out pulse.

Parameters:
- NUM_ACTIONS, 4, number of Q-values per set (>=2).
- IDX_W, 2, width of the action index; must satisfy 2**IDX_W >= NUM_ACTIONS.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort of the set in progress.
- valid_in  input  1  q_in carries the next Q-value of the current set.
- q_in  input  32  fp32 Q-value: [31] sign, [30:23] exponent, [22:0] mantissa.
- max_q  output  32  largest Q-value of the last completed set.
- max_idx  output  IDX_W  action index (0-based arrival order) of max_q.
- valid_out  output  1  one-cycle pulse: max_q/max_idx are new.
- busy  output  1  high while a set is partially received.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, beat counter=0, running max/index=0; max_q=0, max_idx=0, valid_out=0, busy=0.
- State machine has two states:
  - IDLE: no set in progress.
  - ACCUM: beats 1..NUM_ACTIONS-1 of the set received.
- IDLE, valid_in=1:
  - running max <= q_in; running idx <= 0; counter <= 1; go to ACCUM.
- ACCUM, valid_in=1, counter < NUM_ACTIONS-1:
  - If q_in > running max (strict), running max <= q_in and running idx <= counter.
  - counter <= counter+1.
- ACCUM, valid_in=1, counter = NUM_ACTIONS-1 (last beat):
  - Final compare as above, written directly to max_q/max_idx on the same edge.
  - valid_out <= 1 for exactly one cycle; counter <= 0; go to IDLE.
- Latency and throughput:
  - Result is registered on the edge that captures the last beat.
  - valid_out is high in the cycle after the last valid_in.
  - A new set may start in that same cycle (no bubble).
  - Beats need not be consecutive; valid_in=0 cycles hold all state.
- Outputs between sets:
  - max_q/max_idx hold until the next completed set.
  - valid_out=0 whenever no set completes.
- busy = (state==ACCUM).
- clear=1 has priority over valid_in:
  - Return to IDLE, counter <= 0; the beat presented that cycle is discarded.
  - max_q/max_idx keep their last completed values; no valid_out.
- Compare rule, "a > b":
  - Signs differ: a > b iff a is positive and not both operands are zero (+0 and -0 compare equal).
  - Both positive: a[30:0] > b[30:0] unsigned.
  - Both negative: a[30:0] < b[30:0] unsigned.
  - Equal values, including +0/-0: no replacement, so the lowest index wins ties.
- No special NaN/Inf/denormal handling: raw fields are ordered as above, consistent with the adder's normalised-only arithmetic.
- Reset mid-set: everything returns to reset values immediately; the partial set is lost.

Test Plan:
- Basic set: after reset, q_in = 3F800000, 40000000, BF800000, 3F000000 on 4 consecutive cycles -> one cycle after beat 4, valid_out=1, max_q=40000000, max_idx=1; next cycle valid_out=0; busy high from cycle after beat 1 through beat 4.
- All negative with tie: BF800000, C0000000, BF800000, C0400000 -> max_q=BF800000, max_idx=0 (tie keeps lower index).
- Signed zeros and gaps: 80000000, idle 2 cycles, 00000000, BF000000, idle, 80000000 -> max_q=80000000, max_idx=0; valid_out only after beat 4.
- Back-to-back sets: 8 consecutive beats {3F800000, 40400000, 40000000, 3F800000} then {BF800000 x3, 3F000000} -> valid_out pulses in cycles 5 and 9; results (40400000, 1) then (3F000000, 3).
- clear mid-set: beats 40400000, 40000000, then clear=1 together with valid_in=1 (q_in=41000000), then full set {3F800000 x4} -> no pulse for the aborted set; result (3F800000, 0); busy drops in the cycle after clear.
- Async reset: rst_n low for half a cycle after beat 2 of a set -> all outputs 0 immediately; a subsequent full set produces its correct result.
